// File: rtl/vexriscv_dbus_responder.sv
// Environment-side dBus slave for the VexRiscv harness: bounded-stall command accept, in-order read responses.
// Optional VEXRISCV_DBUS_ALIGN_CHECK_EN: misaligned reads answer with rsp_error, misaligned writes raise proto_err.
module vexriscv_dbus_responder #(
    parameter int DEPTH     = 4,
    parameter int MAX_STALL = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   dBus_cmd_valid,
    output logic                   dBus_cmd_ready,
    input  logic                   dBus_cmd_payload_wr,
    input  logic [31:0]            dBus_cmd_payload_address,
    input  logic [31:0]            dBus_cmd_payload_data,
    input  logic [1:0]             dBus_cmd_payload_size,
    output logic                   dBus_rsp_ready,
    output logic [31:0]            dBus_rsp_data,
    output logic                   dBus_rsp_error,
    input  logic                   rand_cmd_accept,
    input  logic                   rand_rsp_fire,
    input  logic [31:0]            rand_rsp_data,
    output logic [$clog2(DEPTH):0] pending_count,
    output logic                   proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(MAX_STALL + 1);
    localparam logic [AW:0]   DEPTH_V = DEPTH[AW:0];
    localparam logic [SW-1:0] STALL_V = MAX_STALL[SW-1:0];

    logic [AW:0]   wrPtr;
    logic [AW:0]   rdPtr;
    logic [AW:0]   count;
    logic [SW-1:0] cmdStall;
    logic [SW-1:0] headAge;
    logic          full;
    logic          headValid;
    logic          handshake;
    logic          push;
    logic          fire;
    logic          prevStalled;
    logic [66:0]   payload;
    logic [66:0]   prevPayload;
    logic          violation;

    assign count     = wrPtr - rdPtr;
    assign full      = (count == DEPTH_V);
    assign headValid = (count != '0);

    // Reset gates cmd_ready so the combinational path also reads 0 while reset is held.
    assign dBus_cmd_ready = !reset && !full && (rand_cmd_accept || cmdStall == STALL_V);
    assign handshake      = dBus_cmd_valid && dBus_cmd_ready;
    assign push           = handshake && !dBus_cmd_payload_wr;
    assign fire           = headValid && (rand_rsp_fire || headAge == STALL_V);
    assign pending_count  = count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            cmdStall <= '0;
            headAge  <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (fire) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (dBus_cmd_valid && !dBus_cmd_ready) begin
                cmdStall <= (cmdStall == STALL_V) ? cmdStall : cmdStall + 1'b1;
            end else begin
                cmdStall <= '0;
            end
            // A head at MAX_STALL always fires, so the age never needs saturation.
            if (fire || !headValid) begin
                headAge <= '0;
            end else begin
                headAge <= headAge + 1'b1;
            end
        end
    end

`ifdef VEXRISCV_DBUS_ALIGN_CHECK_EN
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == 2'd1 && lo[0]) || (size == 2'd2 && lo != 2'd0);
    endfunction

    logic [1:0] sizeMem [DEPTH];
    logic [1:0] addrMem [DEPTH];
    logic       headMis;

    always_ff @(posedge clock) begin
        if (push) begin
            sizeMem[wrPtr[AW-1:0]] <= dBus_cmd_payload_size;
            addrMem[wrPtr[AW-1:0]] <= dBus_cmd_payload_address[1:0];
        end
    end

    assign headMis = isMisaligned(sizeMem[rdPtr[AW-1:0]], addrMem[rdPtr[AW-1:0]]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dBus_rsp_ready <= 1'b0;
            dBus_rsp_data  <= '0;
            dBus_rsp_error <= 1'b0;
        end else begin
            dBus_rsp_ready <= fire;
            dBus_rsp_data  <= (fire && !headMis) ? rand_rsp_data : '0;
            dBus_rsp_error <= fire && headMis;
        end
    end
`else
    assign dBus_rsp_error = 1'b0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dBus_rsp_ready <= 1'b0;
            dBus_rsp_data  <= '0;
        end else begin
            dBus_rsp_ready <= fire;
            dBus_rsp_data  <= fire ? rand_rsp_data : '0;
        end
    end
`endif

    assign payload = {dBus_cmd_payload_wr, dBus_cmd_payload_address,
                      dBus_cmd_payload_data, dBus_cmd_payload_size};

    always_comb begin
        violation = 1'b0;
        if (prevStalled && (!dBus_cmd_valid || payload != prevPayload)) begin
            violation = 1'b1;
        end
        if (dBus_cmd_valid && dBus_cmd_payload_size == 2'd3) begin
            violation = 1'b1;
        end
`ifdef VEXRISCV_DBUS_ALIGN_CHECK_EN
        if (dBus_cmd_valid && dBus_cmd_payload_wr &&
            isMisaligned(dBus_cmd_payload_size, dBus_cmd_payload_address[1:0])) begin
            violation = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prevStalled <= 1'b0;
            prevPayload <= '0;
            proto_err   <= 1'b0;
        end else begin
            prevStalled <= dBus_cmd_valid && !dBus_cmd_ready;
            prevPayload <= payload;
            proto_err   <= proto_err || violation;
        end
    end

endmodule

// File: tb/tb_vexriscv_dbus_responder.sv
// Self-checking bench for vexriscv_dbus_responder: cycle model plus response scoreboard.
module tb_vexriscv_dbus_responder;

    localparam int DEPTH     = 4;
    localparam int MAX_STALL = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmdValid;
    logic        cmdWr;
    logic [31:0] cmdAddr;
    logic [31:0] cmdData;
    logic [1:0]  cmdSize;
    logic        randAccept;
    logic        randFire;
    logic [31:0] randData;

    logic        dBus_cmd_ready;
    logic        dBus_rsp_ready;
    logic [31:0] dBus_rsp_data;
    logic        dBus_rsp_error;
    logic [2:0]  pending_count;
    logic        proto_err;

    always #5 clock = ~clock;

    vexriscv_dbus_responder #(.DEPTH(DEPTH), .MAX_STALL(MAX_STALL)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .dBus_cmd_valid           (cmdValid),
        .dBus_cmd_ready           (dBus_cmd_ready),
        .dBus_cmd_payload_wr      (cmdWr),
        .dBus_cmd_payload_address (cmdAddr),
        .dBus_cmd_payload_data    (cmdData),
        .dBus_cmd_payload_size    (cmdSize),
        .dBus_rsp_ready           (dBus_rsp_ready),
        .dBus_rsp_data            (dBus_rsp_data),
        .dBus_rsp_error           (dBus_rsp_error),
        .rand_cmd_accept          (randAccept),
        .rand_rsp_fire            (randFire),
        .rand_rsp_data            (randData),
        .pending_count            (pending_count),
        .proto_err                (proto_err)
    );

    int          vectors = 0;
    int          miscompares = 0;

    bit          mFifo[$];
    logic [32:0] expQ[$];
    int          mStall;
    int          mAge;
    bit          mRspDue;
    bit          mProto;
    bit          mPrevStalled;
    bit          mLastHs;
    logic [66:0] mPrevPayload;

`ifdef VEXRISCV_DBUS_ALIGN_CHECK_EN
    function automatic bit misal(input logic [1:0] s, input logic [1:0] a);
        return (s == 2'd1 && a[0]) || (s == 2'd2 && a != 2'd0);
    endfunction
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mFifo.delete();
        expQ.delete();
        mStall       = 0;
        mAge         = 0;
        mRspDue      = 0;
        mProto       = 0;
        mPrevStalled = 0;
        mLastHs      = 0;
        mPrevPayload = '0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model to the next rising edge.
    task automatic cycle();
        bit          rdy;
        bit          fire;
        bit          vio;
        bit          m;
        logic [32:0] e;
        @(negedge clock);
        rdy = (mFifo.size() < DEPTH) && (randAccept || mStall == MAX_STALL);
        chk("cmd_ready", 32'(dBus_cmd_ready), 32'(rdy));
        chk("pending_count", 32'(pending_count), 32'(mFifo.size()));
        chk("rsp_ready", 32'(dBus_rsp_ready), 32'(mRspDue));
        chk("proto_err", 32'(proto_err), 32'(mProto));
        if (dBus_rsp_ready === 1'b1) begin
            chk("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                chk("rsp_data", dBus_rsp_data, e[31:0]);
                chk("rsp_error", 32'(dBus_rsp_error), 32'(e[32]));
            end
        end

        fire = (mFifo.size() > 0) && (randFire || mAge == MAX_STALL);
        if (fire) begin
            m = mFifo.pop_front();
            e = m ? {1'b1, 32'h0} : {1'b0, randData};
            expQ.push_back(e);
            mAge = 0;
        end else if (mFifo.size() > 0) begin
            mAge++;
        end

        vio = (mPrevStalled && !cmdValid) ||
              (mPrevStalled && cmdValid && {cmdWr, cmdAddr, cmdData, cmdSize} !== mPrevPayload) ||
              (cmdValid && cmdSize == 2'd3);
`ifdef VEXRISCV_DBUS_ALIGN_CHECK_EN
        vio = vio || (cmdValid && cmdWr && misal(cmdSize, cmdAddr[1:0]));
        m = misal(cmdSize, cmdAddr[1:0]);
`else
        m = 1'b0;
`endif
        mProto = mProto || vio;

        mLastHs = cmdValid && rdy;
        if (mLastHs && !cmdWr) mFifo.push_back(m);
        if (cmdValid && !rdy) mStall = (mStall == MAX_STALL) ? MAX_STALL : mStall + 1;
        else                  mStall = 0;
        mPrevStalled = cmdValid && !rdy;
        mPrevPayload = {cmdWr, cmdAddr, cmdData, cmdSize};
        mRspDue      = fire;
        @(posedge clock);
        #1;
    endtask

    task automatic step(input bit v, input bit wr, input logic [31:0] a, input logic [1:0] s,
                        input bit acc, input bit fr, input logic [31:0] rd);
        cmdValid   = v;
        cmdWr      = wr;
        cmdAddr    = a;
        cmdData    = a ^ 32'hA5A5_0000;
        cmdSize    = s;
        randAccept = acc;
        randFire   = fr;
        randData   = rd;
        cycle();
    endtask

    task automatic idle(input int n, input bit acc, input bit fr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 2'd2, acc, fr, $urandom);
    endtask

    // Hold a command until the model sees it accepted; bounded so a broken DUT cannot hang the run.
    task automatic issue(input bit wr, input logic [31:0] a, input logic [1:0] s,
                         input bit acc, input bit fr);
        int n = 0;
        do begin
            step(1'b1, wr, a, s, acc, fr, $urandom);
            n++;
        end while (!mLastHs && n < 20);
    endtask

    // Async assert mid-cycle, outputs checked before any clock edge, released just after a rising edge.
    task automatic doReset();
        cmdValid   = 1'b0;
        randAccept = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("rst_cmd_ready", 32'(dBus_cmd_ready), 32'd0);
        chk("rst_rsp_ready", 32'(dBus_rsp_ready), 32'd0);
        chk("rst_rsp_data", dBus_rsp_data, 32'd0);
        chk("rst_rsp_error", 32'(dBus_rsp_error), 32'd0);
        chk("rst_pending", 32'(pending_count), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        modelReset();
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        cmdValid   = 1'b0;
        cmdWr      = 1'b0;
        cmdAddr    = '0;
        cmdData    = '0;
        cmdSize    = 2'd2;
        randAccept = 1'b0;
        randFire   = 1'b0;
        randData   = '0;
        modelReset();
        doReset();

        // Single read with immediate accept and fire.
        step(1'b1, 1'b0, 32'h100, 2'd2, 1'b1, 1'b1, 32'hDEADBEEF);
        step(1'b0, 1'b0, 32'h0, 2'd2, 1'b1, 1'b1, 32'hDEADBEEF);
        idle(3, 1'b0, 1'b0);

        // Refused command forced through after MAX_STALL cycles, response forced by head age.
        issue(1'b0, 32'h200, 2'd2, 1'b0, 1'b0);
        idle(6, 1'b0, 1'b0);

        // Fill to DEPTH, fifth read refused while full, forced in-order drain.
        for (int i = 0; i < 5; i++) issue(1'b0, 32'h300 + 32'(4 * i), 2'd2, 1'b1, 1'b0);
        idle(22, 1'b0, 1'b0);

        // Push and pop together at count 2, then stream across many pointer wraps.
        issue(1'b0, 32'h400, 2'd2, 1'b1, 1'b0);
        issue(1'b0, 32'h404, 2'd1, 1'b1, 1'b0);
        issue(1'b0, 32'h408, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) issue(1'b0, 32'h500 + 32'(4 * i), 2'(i % 3), 1'b1, 1'b1);
        idle(8, 1'b0, 1'b1);

        // Random accept/fire mix with a protocol-conforming core.
        for (int i = 0; i < 120; i++) begin
            if (mPrevStalled)
                step(1'b1, cmdWr, cmdAddr, cmdSize, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom);
            else
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                     2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom);
        end
        idle(12, 1'b0, 1'b1);

        // Writes interleaved with reads, then misaligned reads.
        issue(1'b1, 32'h600, 2'd2, 1'b1, 1'b1);
        issue(1'b0, 32'h604, 2'd2, 1'b1, 1'b1);
        issue(1'b1, 32'h608, 2'd2, 1'b1, 1'b1);
        issue(1'b0, 32'h60C, 2'd1, 1'b1, 1'b1);
        idle(3, 1'b0, 1'b1);
        issue(1'b0, 32'h102, 2'd2, 1'b1, 1'b1);
        issue(1'b0, 32'h101, 2'd1, 1'b1, 1'b1);
        issue(1'b0, 32'h102, 2'd1, 1'b1, 1'b1);
        idle(4, 1'b0, 1'b1);

        // Valid dropped while stalled: sticky protocol error.
        step(1'b1, 1'b0, 32'h700, 2'd2, 1'b0, 1'b0, $urandom);
        idle(4, 1'b0, 1'b0);

        // Reset with three reads pending: nothing stale afterwards.
        doReset();
        for (int i = 0; i < 3; i++) issue(1'b0, 32'h800 + 32'(4 * i), 2'd2, 1'b1, 1'b0);
        doReset();
        idle(6, 1'b1, 1'b1);

        // Payload changed while stalled.
        step(1'b1, 1'b0, 32'h900, 2'd2, 1'b0, 1'b0, $urandom);
        step(1'b1, 1'b0, 32'h904, 2'd2, 1'b0, 1'b0, $urandom);
        idle(3, 1'b1, 1'b1);

        // Illegal size 3.
        doReset();
        step(1'b1, 1'b0, 32'hA00, 2'd3, 1'b1, 1'b0, $urandom);
        idle(4, 1'b0, 1'b1);

        chk("sb_drained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
